// File: rtl/processing_element_ws_db.sv
// Weight-stationary MAC PE with shadow/active double-buffered weight for systolic grids.
// Optional saturating accumulate enabled by defining PE_SAT_EN (default: wrap-around, sat_out tied 0).
module processing_element_ws_db #(
  parameter int WORDWIDTH = 8,
  parameter int PSWIDTH   = 32,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 w_load_in,
  input  logic [WORDWIDTH-1:0] w_in,
  input  logic                 w_swap_in,
  input  logic                 enable_in,
  input  logic [WORDWIDTH-1:0] a_in,
  input  logic [PSWIDTH-1:0]   ps_in,
  output logic                 w_load_out,
  output logic [WORDWIDTH-1:0] w_out,
  output logic                 w_swap_out,
  output logic                 enable_out,
  output logic [WORDWIDTH-1:0] a_out,
  output logic [PSWIDTH-1:0]   ps_out,
  output logic                 sat_out
);

  // State encoding is {shadow_v, active_v}
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ACTIVE = 2'b01,
    PRIMED = 2'b10,
    FULL   = 2'b11
  } wstate_t;

  wstate_t              state_q, state_d;
  logic [WORDWIDTH-1:0] shadow_q, shadow_d;
  logic [WORDWIDTH-1:0] active_q, active_d;
  logic                 w_load_q, w_swap_q, enable_q;
  logic [WORDWIDTH-1:0] w_q, a_q, a_d;
  logic [PSWIDTH-1:0]   ps_q, ps_d;

  logic                 shadow_v, active_v;
  logic [WORDWIDTH-1:0] w_act;
  logic [PSWIDTH-1:0]   prod_ext;
  logic [PSWIDTH-1:0]   sum;
  logic [PSWIDTH-1:0]   mac;
  logic                 ovf;

  assign shadow_v = state_q[1];
  assign active_v = state_q[0];
  // MAC always sees the pre-swap weight; a commit this cycle takes effect next cycle
  assign w_act    = active_v ? active_q : '0;

  always_comb begin
    logic sv_n, av_n;
    shadow_d = shadow_q;
    active_d = active_q;
    sv_n     = shadow_v;
    av_n     = active_v;
    if (w_swap_in && shadow_v) begin
      active_d = shadow_q;
      av_n     = 1'b1;
      sv_n     = 1'b0;
    end
    // Applied after the swap so load+swap commits the old shadow and keeps the new one pending
    if (w_load_in) begin
      shadow_d = w_in;
      sv_n     = 1'b1;
    end
    state_d = wstate_t'({sv_n, av_n});
  end

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*WORDWIDTH-1:0] prod_s;
      assign prod_s   = $signed(a_in) * $signed(w_act);
      assign prod_ext = PSWIDTH'(prod_s);
    end else begin : g_unsigned
      logic [2*WORDWIDTH-1:0] prod_u;
      assign prod_u   = a_in * w_act;
      assign prod_ext = PSWIDTH'(prod_u);
    end
  endgenerate

  assign sum = ps_in + prod_ext;

`ifdef PE_SAT_EN
  logic [PSWIDTH-1:0] clamp;
  logic               sat_q, sat_d;

  generate
    if (SIGNED != 0) begin : g_sat_signed
      // Overflow only when both operands share a sign that the result does not
      assign ovf   = (ps_in[PSWIDTH-1] == prod_ext[PSWIDTH-1]) &&
                     (sum[PSWIDTH-1] != ps_in[PSWIDTH-1]);
      assign clamp = ps_in[PSWIDTH-1] ? {1'b1, {(PSWIDTH-1){1'b0}}}
                                      : {1'b0, {(PSWIDTH-1){1'b1}}};
    end else begin : g_sat_unsigned
      assign ovf   = (sum < ps_in);
      assign clamp = '1;
    end
  endgenerate

  assign mac     = ovf ? clamp : sum;
  assign sat_d   = enable_in ? ovf : sat_q;
  assign sat_out = sat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sat_q <= 1'b0;
    else          sat_q <= sat_d;
  end
`else
  assign ovf     = 1'b0;
  assign mac     = sum;
  assign sat_out = 1'b0;
`endif

  always_comb begin
    ps_d = ps_q;
    a_d  = a_q;
    if (enable_in && !ovf) begin
      ps_d = mac;
      a_d  = a_in;
    end else if (enable_in) begin
      ps_d = mac;
      a_d  = a_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      shadow_q <= '0;
      active_q <= '0;
      w_load_q <= 1'b0;
      w_swap_q <= 1'b0;
      enable_q <= 1'b0;
      w_q      <= '0;
      a_q      <= '0;
      ps_q     <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      w_load_q <= w_load_in;
      w_swap_q <= w_swap_in;
      enable_q <= enable_in;
      w_q      <= w_in;
      a_q      <= a_d;
      ps_q     <= ps_d;
    end
  end

  assign w_load_out = w_load_q;
  assign w_out      = w_q;
  assign w_swap_out = w_swap_q;
  assign enable_out = enable_q;
  assign a_out      = a_q;
  assign ps_out     = ps_q;

endmodule

// File: tb/tb_processing_element_ws_db.sv
// Directed table-driven bench: signed and unsigned PE instances share one stimulus stream.
module tb_processing_element_ws_db;

`ifdef PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w_load_in, w_swap_in, enable_in;
  logic [7:0]  w_in, a_in;
  logic [31:0] ps_in;

  logic        w_load_out, w_swap_out, enable_out, sat_out;
  logic [7:0]  w_out, a_out;
  logic [31:0] ps_out;

  logic        u_w_load_out, u_w_swap_out, u_enable_out, u_sat_out;
  logic [7:0]  u_w_out, u_a_out;
  logic [31:0] u_ps_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  processing_element_ws_db #(.WORDWIDTH(8), .PSWIDTH(32), .SIGNED(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .w_load_in(w_load_in), .w_in(w_in), .w_swap_in(w_swap_in),
    .enable_in(enable_in), .a_in(a_in), .ps_in(ps_in),
    .w_load_out(w_load_out), .w_out(w_out), .w_swap_out(w_swap_out),
    .enable_out(enable_out), .a_out(a_out), .ps_out(ps_out), .sat_out(sat_out)
  );

  processing_element_ws_db #(.WORDWIDTH(8), .PSWIDTH(32), .SIGNED(0)) dut_u (
    .clk(clk), .reset_n(reset_n),
    .w_load_in(w_load_in), .w_in(w_in), .w_swap_in(w_swap_in),
    .enable_in(enable_in), .a_in(a_in), .ps_in(ps_in),
    .w_load_out(u_w_load_out), .w_out(u_w_out), .w_swap_out(u_w_swap_out),
    .enable_out(u_enable_out), .a_out(u_a_out), .ps_out(u_ps_out), .sat_out(u_sat_out)
  );

  typedef struct {
    logic        ld;
    logic [7:0]  w;
    logic        sw;
    logic        en;
    logic [7:0]  a;
    logic [31:0] ps;
    logic [31:0] e_ps;
    logic [31:0] e_psu;
    logic [7:0]  e_a;
    logic        e_en;
    logic        e_sat;
    logic        e_satu;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic [7:0] w, input logic sw, input logic en,
                     input logic [7:0] a, input logic [31:0] ps,
                     input logic [31:0] e_ps, input logic [31:0] e_psu, input logic [7:0] e_a,
                     input logic e_en, input logic e_sat, input logic e_satu);
    vec_t v;
    v.ld = ld; v.w = w; v.sw = sw; v.en = en; v.a = a; v.ps = ps;
    v.e_ps = e_ps; v.e_psu = e_psu; v.e_a = e_a; v.e_en = e_en;
    v.e_sat = e_sat; v.e_satu = e_satu;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] w, input logic sw, input logic en,
                       input logic [7:0] a, input logic [31:0] ps);
    w_load_in = ld; w_in = w; w_swap_in = sw; enable_in = en; a_in = a; ps_in = ps;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 32'h0);

    //   ld w     sw en a      ps            e_ps                      e_psu                     e_a   en sat  satu
    add(1, 8'h03, 0, 0, 8'h00, 32'd0,        32'd0,                    32'd0,                    8'h00, 0, 0,   0);
    add(0, 8'h00, 1, 0, 8'h00, 32'd0,        32'd0,                    32'd0,                    8'h00, 0, 0,   0);
    add(0, 8'h00, 0, 1, 8'h02, 32'd5,        32'd11,                   32'd11,                   8'h02, 1, 0,   0);
    add(1, 8'h07, 0, 1, 8'h02, 32'd5,        32'd11,                   32'd11,                   8'h02, 1, 0,   0);
    add(0, 8'h00, 1, 1, 8'h02, 32'd5,        32'd11,                   32'd11,                   8'h02, 1, 0,   0);
    add(0, 8'h00, 0, 1, 8'h02, 32'd5,        32'd19,                   32'd19,                   8'h02, 1, 0,   0);
    add(0, 8'h00, 0, 0, 8'h09, 32'd100,      32'd19,                   32'd19,                   8'h02, 0, 0,   0);
    add(1, 8'h04, 0, 0, 8'h00, 32'd0,        32'd19,                   32'd19,                   8'h02, 0, 0,   0);
    add(1, 8'h09, 1, 0, 8'h00, 32'd0,        32'd19,                   32'd19,                   8'h02, 0, 0,   0);
    add(0, 8'h00, 0, 1, 8'h01, 32'd0,        32'd4,                    32'd4,                    8'h01, 1, 0,   0);
    add(0, 8'h00, 1, 0, 8'h00, 32'd0,        32'd4,                    32'd4,                    8'h01, 0, 0,   0);
    add(0, 8'h00, 0, 1, 8'h01, 32'd0,        32'd9,                    32'd9,                    8'h01, 1, 0,   0);
    add(1, 8'hFF, 0, 0, 8'h00, 32'd0,        32'd9,                    32'd9,                    8'h01, 0, 0,   0);
    add(0, 8'h00, 1, 0, 8'h00, 32'd0,        32'd9,                    32'd9,                    8'h01, 0, 0,   0);
    add(0, 8'h00, 0, 1, 8'h80, 32'd0,        32'd128,                  32'd32640,                8'h80, 1, 0,   0);
    add(1, 8'h01, 0, 0, 8'h00, 32'd0,        32'd128,                  32'd32640,                8'h80, 0, 0,   0);
    add(0, 8'h00, 1, 0, 8'h00, 32'd0,        32'd128,                  32'd32640,                8'h80, 0, 0,   0);
    add(0, 8'h00, 0, 1, 8'h01, 32'h7FFFFFFF, SAT ? 32'h7FFFFFFF : 32'h80000000,
                                                                       32'h80000000,             8'h01, 1, SAT, 0);
    add(0, 8'h00, 0, 1, 8'hFE, 32'd10,       32'd8,                    32'd264,                  8'hFE, 1, 0,   0);
    add(0, 8'h00, 0, 1, 8'h01, 32'hFFFFFFFF, 32'd0,                    SAT ? 32'hFFFFFFFF : 32'd0,
                                                                                                 8'h01, 1, 0,   SAT);
    add(0, 8'h00, 0, 1, 8'hFF, 32'h80000000, SAT ? 32'h80000000 : 32'h7FFFFFFF,
                                                                       32'h800000FF,             8'hFF, 1, SAT, 0);

    #2;
    chk("reset ps_out", ps_out, 32'd0);
    chk("reset a_out", {24'd0, a_out}, 32'd0);
    chk("reset enable_out", {31'd0, enable_out}, 32'd0);
    chk("reset w_out", {24'd0, w_out}, 32'd0);
    chk("reset sat_out", {31'd0, sat_out}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].w, vecs[i].sw, vecs[i].en, vecs[i].a, vecs[i].ps);
      step();
      $display("row %0d: ld=%0b w=%02h sw=%0b en=%0b a=%02h ps=%08h -> ps_out=%08h u_ps_out=%08h sat=%0b",
               i, vecs[i].ld, vecs[i].w, vecs[i].sw, vecs[i].en, vecs[i].a, vecs[i].ps,
               ps_out, u_ps_out, sat_out);
      chk($sformatf("row%0d ps_out", i), ps_out, vecs[i].e_ps);
      chk($sformatf("row%0d u_ps_out", i), u_ps_out, vecs[i].e_psu);
      chk($sformatf("row%0d a_out", i), {24'd0, a_out}, {24'd0, vecs[i].e_a});
      chk($sformatf("row%0d enable_out", i), {31'd0, enable_out}, {31'd0, vecs[i].e_en});
      chk($sformatf("row%0d w_out", i), {24'd0, w_out}, {24'd0, vecs[i].w});
      chk($sformatf("row%0d w_load_out", i), {31'd0, w_load_out}, {31'd0, vecs[i].ld});
      chk($sformatf("row%0d w_swap_out", i), {31'd0, w_swap_out}, {31'd0, vecs[i].sw});
      chk($sformatf("row%0d sat_out", i), {31'd0, sat_out}, {31'd0, vecs[i].e_sat});
      chk($sformatf("row%0d u_sat_out", i), {31'd0, u_sat_out}, {31'd0, vecs[i].e_satu});
    end

    // Mid-stream reset: outputs clear asynchronously, both weights are discarded
    drive(1, 8'h05, 0, 1, 8'h03, 32'd1000);
    #2 reset_n = 1'b0;
    #1;
    $display("async reset: ps_out=%08h a_out=%02h en=%0b w_out=%02h", ps_out, a_out, enable_out, w_out);
    chk("async reset ps_out", ps_out, 32'd0);
    chk("async reset a_out", {24'd0, a_out}, 32'd0);
    chk("async reset enable_out", {31'd0, enable_out}, 32'd0);
    chk("async reset w_load_out", {31'd0, w_load_out}, 32'd0);
    chk("async reset u_ps_out", u_ps_out, 32'd0);
    step();
    drive(0, 8'h00, 0, 0, 8'h00, 32'd0);
    reset_n = 1'b1;

    drive(0, 8'h00, 1, 0, 8'h00, 32'd0);
    step();
    $display("post-reset swap: w_swap_out=%0b", w_swap_out);
    chk("post-reset swap w_swap_out", {31'd0, w_swap_out}, 32'd1);
    drive(0, 8'h00, 1, 1, 8'h05, 32'd77);
    step();
    $display("post-reset swap+mac: ps_out=%08h", ps_out);
    chk("post-reset swap+mac ps_out", ps_out, 32'd77);
    drive(0, 8'h00, 0, 1, 8'h05, 32'd77);
    step();
    $display("post-reset mac: ps_out=%08h u_ps_out=%08h a_out=%02h", ps_out, u_ps_out, a_out);
    chk("post-reset mac ps_out", ps_out, 32'd77);
    chk("post-reset mac u_ps_out", u_ps_out, 32'd77);
    chk("post-reset mac a_out", {24'd0, a_out}, 32'd5);

    // A fresh load after reset must become effective again
    drive(1, 8'h06, 0, 0, 8'h00, 32'd0);
    step();
    drive(0, 8'h00, 1, 0, 8'h00, 32'd0);
    step();
    drive(0, 8'h00, 0, 1, 8'h05, 32'd77);
    step();
    $display("reload mac: ps_out=%08h", ps_out);
    chk("reload mac ps_out", ps_out, 32'd107);

    drive(0, 8'h00, 0, 0, 8'h00, 32'd0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
